// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, loadable word-addressed instruction memory and the
// IF/ID pipeline register, with stall hold and branch redirect/bubble insertion.
module if_stage #(
    parameter int          IMEM_DEPTH = 64,
    parameter int          ADDR_BITS  = 6,
    parameter logic [31:0] RESET_PC   = 32'd0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 freez,
    input  logic                 branch_taken,
    input  logic [31:0]          branch_addr,
    input  logic                 imem_we,
    input  logic [ADDR_BITS-1:0] imem_addr,
    input  logic [31:0]          imem_wdata,
    output logic [31:0]          instruction,
    output logic [31:0]          PCOut,
    output logic                 flushOut,
    output logic [15:0]          fetch_count,
    output logic [15:0]          flush_count
);

    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        MODE_NORMAL,
        MODE_STALL,
        MODE_REDIRECT
    } mode_e;

    logic [31:0] imem [IMEM_DEPTH];

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcout_q, pcout_d;
    logic        flush_q, flush_d;
    logic [15:0] fcnt_q, fcnt_d;
    logic [15:0] bcnt_q, bcnt_d;

    logic [ADDR_BITS-1:0] fetch_idx;
    logic                 fetch_in_range;
    logic [31:0]          fetch_word;
    logic [31:0]          pc_plus4;
    mode_e                mode;

    // Program load; not reset so contents survive a pipeline reset.
    always_ff @(posedge clk) begin
        if (rst && imem_we)
            imem[imem_addr] <= imem_wdata;
    end

    // Addresses past the end of memory fetch a NOP rather than aliasing.
    assign fetch_idx      = pc_q[ADDR_BITS+1:2];
    assign fetch_in_range = (pc_q[31:ADDR_BITS+2] == '0);
    assign fetch_word     = fetch_in_range ? imem[fetch_idx] : 32'd0;
    assign pc_plus4       = pc_q + 32'd4;

    always_comb begin
        mode = MODE_NORMAL;
        if (branch_taken)
            mode = MODE_REDIRECT;
        else if (freez)
            mode = MODE_STALL;
    end

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pcout_d = pcout_q;
        flush_d = flush_q;
        fcnt_d  = fcnt_q;
        bcnt_d  = bcnt_q;
        unique case (mode)
            MODE_REDIRECT: begin
                pc_d    = {branch_addr[31:2], 2'b00};
                instr_d = 32'd0;
                pcout_d = 32'd0;
                flush_d = 1'b1;
                if (bcnt_q != 16'hFFFF)
                    bcnt_d = bcnt_q + 16'd1;
            end
            MODE_STALL: ;
            MODE_NORMAL: begin
                pc_d    = pc_plus4;
                instr_d = fetch_word;
                pcout_d = pc_plus4;
                flush_d = 1'b0;
                if (fcnt_q != 16'hFFFF)
                    fcnt_d = fcnt_q + 16'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= PC_INIT;
            instr_q <= 32'd0;
            pcout_q <= 32'd0;
            flush_q <= 1'b0;
            fcnt_q  <= 16'd0;
            bcnt_q  <= 16'd0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcout_q <= pcout_d;
            flush_q <= flush_d;
            fcnt_q  <= fcnt_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign instruction = instr_q;
    assign PCOut       = pcout_q;
    assign flushOut    = flush_q;
    assign fetch_count = fcnt_q;
    assign flush_count = bcnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, fetch, stall, redirect, load hazards,
// out-of-range fetch, async reset and counter saturation.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freez;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_we;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [31:0] instruction;
    logic [31:0] PCOut;
    logic        flushOut;
    logic [15:0] fetch_count;
    logic [15:0] flush_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] prog [8];

    if_stage #(.IMEM_DEPTH(64), .ADDR_BITS(6), .RESET_PC(32'd0)) dut (
        .clk(clk), .rst(rst), .freez(freez), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .instruction(instruction), .PCOut(PCOut),
        .flushOut(flushOut), .fetch_count(fetch_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; freez = 1'b0; branch_taken = 1'b0; branch_addr = '0;
        imem_we = 1'b0; imem_addr = '0; imem_wdata = '0;
        #2;
        n_checks++;
        if (instruction !== 32'd0 || PCOut !== 32'd0 || flushOut !== 1'b0 ||
            fetch_count !== 16'd0 || flush_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: instr=%h pcout=%h flush=%b fc=%0d bc=%0d, want all 0",
                     instruction, PCOut, flushOut, fetch_count, flush_count);
        end
        // Load the program with the pipe stalled, then reset again.
        prog[0] = 32'h04000001; prog[1] = 32'h0C000002; prog[2] = 32'h14000003;
        prog[3] = 32'h18000004; prog[4] = 32'h20000005; prog[5] = 32'h24000006;
        prog[6] = 32'h28000007; prog[7] = 32'h2C000008;
        rst = 1'b1; freez = 1'b1;
        for (int i = 0; i < 8; i++) begin
            imem_we = 1'b1; imem_addr = 6'(i); imem_wdata = prog[i];
            tick();
        end
        imem_addr = 6'd63; imem_wdata = 32'h3F3F3F3F;
        tick();
        imem_we = 1'b0;
        n_checks++;
        if (instruction !== 32'd0 || fetch_count !== 16'd0) begin
            n_fail++;
            $display("FAIL load_while_stalled: instr=%h fc=%0d, want 0 / 0", instruction, fetch_count);
        end
        // A write attempted during reset must be dropped.
        rst = 1'b0; imem_we = 1'b1; imem_addr = 6'd4; imem_wdata = 32'hDEADBEEF;
        tick();
        tick();
        imem_we = 1'b0; rst = 1'b1; freez = 1'b0;
    endtask

    task automatic test_fetch();
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_checks++;
            if (instruction !== prog[k-1] || PCOut !== 32'(4*k) || flushOut !== 1'b0 ||
                fetch_count !== 16'(k)) begin
                n_fail++;
                $display("FAIL fetch_%0d: instr=%h pcout=%h flush=%b fc=%0d, want %h %h 0 %0d",
                         k, instruction, PCOut, flushOut, fetch_count, prog[k-1], 4*k, k);
            end
        end
    endtask

    task automatic test_stall();
        pulse_reset();
        tick(); tick();
        freez = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (instruction !== 32'h0C000002 || PCOut !== 32'd8 || fetch_count !== 16'd2 ||
                flushOut !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: instr=%h pcout=%h fc=%0d flush=%b, want 0c000002 8 2 0",
                         k, instruction, PCOut, fetch_count, flushOut);
            end
        end
        freez = 1'b0;
        tick();
        n_checks++;
        if (instruction !== 32'h14000003 || PCOut !== 32'd12 || fetch_count !== 16'd3) begin
            n_fail++;
            $display("FAIL stall_release: instr=%h pcout=%h fc=%0d, want 14000003 c 3",
                     instruction, PCOut, fetch_count);
        end
    endtask

    task automatic test_redirect();
        branch_taken = 1'b1; branch_addr = 32'h0000000E;
        tick();
        branch_taken = 1'b0;
        n_checks++;
        if (instruction !== 32'd0 || PCOut !== 32'd0 || flushOut !== 1'b1 ||
            flush_count !== 16'd1 || fetch_count !== 16'd3) begin
            n_fail++;
            $display("FAIL redirect_bubble: instr=%h pcout=%h flush=%b bc=%0d fc=%0d, want 0 0 1 1 3",
                     instruction, PCOut, flushOut, flush_count, fetch_count);
        end
        tick();
        n_checks++;
        if (instruction !== 32'h18000004 || PCOut !== 32'd16 || flushOut !== 1'b0 ||
            fetch_count !== 16'd4) begin
            n_fail++;
            $display("FAIL redirect_target: instr=%h pcout=%h flush=%b fc=%0d, want 18000004 10 0 4",
                     instruction, PCOut, flushOut, fetch_count);
        end
        tick();
        n_checks++;
        if (instruction !== 32'h20000005 || PCOut !== 32'd20) begin
            n_fail++;
            $display("FAIL write_in_reset_ignored: instr=%h pcout=%h, want 20000005 14",
                     instruction, PCOut);
        end
    endtask

    task automatic test_redirect_in_stall();
        freez = 1'b1; branch_taken = 1'b1; branch_addr = 32'd4;
        tick();
        branch_taken = 1'b0;
        n_checks++;
        if (instruction !== 32'd0 || PCOut !== 32'd0 || flushOut !== 1'b1 || flush_count !== 16'd2) begin
            n_fail++;
            $display("FAIL stall_redirect_bubble: instr=%h pcout=%h flush=%b bc=%0d, want 0 0 1 2",
                     instruction, PCOut, flushOut, flush_count);
        end
        tick();
        n_checks++;
        if (instruction !== 32'd0 || flushOut !== 1'b1 || flush_count !== 16'd2 || fetch_count !== 16'd5) begin
            n_fail++;
            $display("FAIL stall_bubble_hold: instr=%h flush=%b bc=%0d fc=%0d, want 0 1 2 5",
                     instruction, flushOut, flush_count, fetch_count);
        end
        freez = 1'b0;
        tick();
        n_checks++;
        if (instruction !== 32'h0C000002 || PCOut !== 32'd8 || flushOut !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_redirect_target: instr=%h pcout=%h flush=%b, want 0c000002 8 0",
                     instruction, PCOut, flushOut);
        end
    endtask

    task automatic test_back_to_back();
        branch_taken = 1'b1; branch_addr = 32'h18;
        tick();
        branch_addr = 32'h8;
        tick();
        branch_taken = 1'b0;
        n_checks++;
        if (flushOut !== 1'b1 || instruction !== 32'd0 || flush_count !== 16'd4) begin
            n_fail++;
            $display("FAIL b2b_bubble: flush=%b instr=%h bc=%0d, want 1 0 4", flushOut, instruction, flush_count);
        end
        tick();
        n_checks++;
        if (instruction !== 32'h14000003 || PCOut !== 32'd12 || flushOut !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_target: instr=%h pcout=%h flush=%b, want 14000003 c 0",
                     instruction, PCOut, flushOut);
        end
    endtask

    task automatic test_read_before_write();
        imem_we = 1'b1; imem_addr = 6'd3; imem_wdata = 32'hCAFEF00D;
        tick();
        imem_we = 1'b0;
        n_checks++;
        if (instruction !== 32'h18000004 || PCOut !== 32'd16) begin
            n_fail++;
            $display("FAIL rbw_old_data: instr=%h pcout=%h, want 18000004 10", instruction, PCOut);
        end
        branch_taken = 1'b1; branch_addr = 32'hC;
        tick();
        branch_taken = 1'b0;
        tick();
        n_checks++;
        if (instruction !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL rbw_new_data: instr=%h, want cafef00d", instruction);
        end
    endtask

    task automatic test_out_of_range();
        branch_taken = 1'b1; branch_addr = 32'hFC;
        tick();
        branch_taken = 1'b0;
        tick();
        n_checks++;
        if (instruction !== 32'h3F3F3F3F || PCOut !== 32'h100) begin
            n_fail++;
            $display("FAIL last_word: instr=%h pcout=%h, want 3f3f3f3f 100", instruction, PCOut);
        end
        for (int k = 1; k <= 2; k++) begin
            tick();
            n_checks++;
            if (instruction !== 32'd0 || PCOut !== 32'h100 + 32'(4*k)) begin
                n_fail++;
                $display("FAIL oor_nop_%0d: instr=%h pcout=%h, want 0 %h",
                         k, instruction, PCOut, 32'h100 + 32'(4*k));
            end
        end
    endtask

    task automatic test_async_reset();
        branch_taken = 1'b1; branch_addr = 32'h40;
        tick();
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (instruction !== 32'd0 || PCOut !== 32'd0 || flushOut !== 1'b0 ||
            fetch_count !== 16'd0 || flush_count !== 16'd0) begin
            n_fail++;
            $display("FAIL async_reset: instr=%h pcout=%h flush=%b fc=%0d bc=%0d, want all 0",
                     instruction, PCOut, flushOut, fetch_count, flush_count);
        end
        #1;
        branch_taken = 1'b0; rst = 1'b1;
        tick();
        n_checks++;
        if (instruction !== 32'h04000001 || PCOut !== 32'd4 || fetch_count !== 16'd1) begin
            n_fail++;
            $display("FAIL reset_pc_fetch: instr=%h pcout=%h fc=%0d, want 04000001 4 1",
                     instruction, PCOut, fetch_count);
        end
    endtask

    task automatic test_saturation();
        repeat (70000) @(posedge clk);
        #1;
        n_checks++;
        if (fetch_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL fetch_saturate: fc=%h, want ffff", fetch_count);
        end
        n_checks++;
        if (flush_count !== 16'd0) begin
            n_fail++;
            $display("FAIL flush_count_hold: bc=%0d, want 0", flush_count);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_redirect();
        test_redirect_in_stall();
        test_back_to_back();
        test_read_before_write();
        test_out_of_range();
        test_async_reset();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
